// File: rtl/mg_div_pkg.sv
// Shared types and helpers for the sequential divider: FSM states, counter sizing,
// and the P/G prefix cell also used by the multiplier final-adder generators.
package mg_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Returns {g_out, p_out} for a (hi, lo) group merge.
  function automatic logic [1:0] pg_cell(input logic g_hi, input logic p_hi,
                                         input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

endpackage

// File: rtl/mg_cpa_sub.sv
// Combinational N-bit Brent-Kung subtractor: diff = a - b computed as a + ~b + 1,
// borrow is the inverted carry out.
module mg_cpa_sub
  import mg_div_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  localparam int LEVELS = $clog2(N);

  logic [N-1:0] hp;
  logic [N-1:0] gg;
  logic [N-1:0] pp;

  assign hp = a_i ^ ~b_i;

  always_comb begin
    gg = a_i & ~b_i;
    pp = hp;
    // Fold the +1 carry-in into bit 0 so gg[i] becomes the carry out of bit i.
    gg[0] = gg[0] | pp[0];
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (i >= (1 << l)) ? i - (1 << l) : 0;
        if (((i + 1) % (2 << l)) == 0)
          {gg[i], pp[i]} = pg_cell(gg[i], pp[i], gg[j], pp[j]);
      end
    end
    for (int l = LEVELS - 2; l >= 0; l--) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (i >= (1 << l)) ? i - (1 << l) : 0;
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l)))
          {gg[i], pp[i]} = pg_cell(gg[i], pp[i], gg[j], pp[j]);
      end
    end
  end

  assign diff_o   = hp ^ {gg[N-2:0], 1'b1};
  assign borrow_o = ~gg[N-1];

endmodule

// File: rtl/mg_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional MG_DIV_FASTPATH_EN: divide-by-zero and dividend<divisor finish straight from accept.
module mg_seq_divider
  import mg_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d, rem_q, rem_d, dvsr_q, dvsr_d, dvd_q, dvd_d;
  logic [WIDTH-1:0]   quo_q, quo_d, rmd_q, rmd_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     r_sh, t_diff;
  logic               t_borrow;
  logic               unused_bits;

  assign r_sh = {rem_q, q_q[WIDTH-1]};

  mg_cpa_sub #(.N(WIDTH + 1)) u_sub (
    .a_i      (r_sh),
    .b_i      ({1'b0, dvsr_q}),
    .diff_o   (t_diff),
    .borrow_o (t_borrow)
  );

`ifdef MG_DIV_FASTPATH_EN
  logic [WIDTH:0] fp_diff;
  logic           fp_lt;

  mg_cpa_sub #(.N(WIDTH + 1)) u_fp_cmp (
    .a_i      ({1'b0, dividend}),
    .b_i      ({1'b0, divisor}),
    .diff_o   (fp_diff),
    .borrow_o (fp_lt)
  );

  assign unused_bits = t_diff[WIDTH] ^ (^fp_diff);
`else
  assign unused_bits = t_diff[WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvsr_d  = divisor;
          dvd_d   = dividend;
          q_d     = dividend;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef MG_DIV_FASTPATH_EN
          if ((divisor == '0) || fp_lt) begin
            state_d = DONE;
            quo_d   = (divisor == '0) ? '1 : '0;
            rmd_d   = dividend;
            dbz_d   = (divisor == '0);
          end
`endif
        end
      end
      CALC: begin
        if (!t_borrow) begin
          rem_d = t_diff[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = r_sh[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        // Last iteration: publish straight from the next-state values.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          dbz_d   = (dvsr_q == '0);
          quo_d   = (dvsr_q == '0) ? '1 : q_d;
          rmd_d   = (dvsr_q == '0) ? dvd_q : rem_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mg_seq_divider.sv
// Self-checking bench for mg_seq_divider (WIDTH=4): directed cases plus randomized ops
// against an arithmetic reference model. Honors MG_DIV_FASTPATH_EN for latency.
module tb_mg_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mg_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int a, input int b);
`ifdef MG_DIV_FASTPATH_EN
    if (b == 0 || a < b) return 1;
`endif
    return W + 1;
  endfunction

  // Issues one op, optionally noising in_valid while busy, then holds the result for
  // 'hold' cycles with out_ready low before releasing it.
  task automatic run_op(input int a, input int b, input int hold, input bit noise);
    int lat, guard, eq, er, ez;
    if (b == 0) begin eq = (1 << W) - 1; er = a; ez = 1; end
    else begin eq = a / b; er = a % b; ez = 0; end
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    dividend  = W'(a);
    divisor   = W'(b);
    out_ready = 1'b0;
    tick();
    dividend = W'($urandom);
    divisor  = W'($urandom);
    in_valid = noise ? 1'($urandom) : 1'b0;
    lat = 1;
    if (!out_valid) begin
      check("in_ready_calc", {31'd0, in_ready}, 32'd0);
      check("busy_calc", {31'd0, busy}, 32'd1);
    end
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      in_valid = noise ? 1'($urandom) : 1'b0;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat(a, b));
    for (int h = 0; h <= hold; h++) begin
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("quotient", {28'd0, quotient}, eq);
      check("remainder", {28'd0, remainder}, er);
      check("div_by_zero", {31'd0, div_by_zero}, ez);
      check("in_ready_done", {31'd0, in_ready}, 32'd0);
      if (h < hold) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_pop", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_pop", {31'd0, in_ready}, 32'd1);
    check("quotient_kept", {28'd0, quotient}, eq);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_quotient"}, {28'd0, quotient}, 32'd0);
    check({tag, "_remainder"}, {28'd0, remainder}, 32'd0);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    run_op(13, 3, 0, 1'b0);
    run_op(15, 1, 0, 1'b0);
    run_op(0, 7, 0, 1'b0);
    run_op(7, 0, 0, 1'b0);
    run_op(9, 2, 3, 1'b0);
    run_op(2, 9, 0, 1'b0);
    run_op(15, 15, 0, 1'b0);
    run_op(0, 0, 1, 1'b0);

    // Abort an op mid-CALC with a one-cycle reset.
    in_valid = 1'b1; dividend = 4'd11; divisor = 4'd3;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("abort");
    run_op(6, 4, 0, 1'b0);

    for (int k = 0; k < 2000; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 2), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
